// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic note scheduler. Accepts note-on/off events and
// assigns each to one of NUM_VOICES oscillator+ar voice slots. Idle voices are
// reused first; when every voice is busy the oldest one is stolen after a
// gate-low gap long enough for its envelope to release.
// Ports:
//   clk_i, rst_ni                     clock, async active-low reset
//   ev_valid_i / ev_ready_o           event handshake (ready only in IDLE)
//   ev_on_i, ev_note_i, ev_increment_i event payload
//   all_off_i                         panic: release every voice
//   voice_inc_o                       per-voice increment, voice i at [i*INC_W +: INC_W]
//   voice_gate_o                      per-voice gate
//   stolen_o                          1-cycle pulse when a voice is stolen
module voice_allocator #(
   parameter int unsigned NUM_VOICES = 4,
   parameter int unsigned NOTE_W     = 7,
   parameter int unsigned INC_W      = 16,
   parameter int unsigned GATE_GAP   = 512
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        ev_valid_i,
   output logic                        ev_ready_o,
   input  logic                        ev_on_i,
   input  logic [NOTE_W-1:0]           ev_note_i,
   input  logic [INC_W-1:0]            ev_increment_i,
   input  logic                        all_off_i,
   output logic [NUM_VOICES*INC_W-1:0] voice_inc_o,
   output logic [NUM_VOICES-1:0]       voice_gate_o,
   output logic                        stolen_o
);

   localparam int unsigned IDX_W = $clog2(NUM_VOICES);
   localparam int unsigned CNT_W = $clog2(GATE_GAP + 1);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_GAP, S_COMMIT} state_e;

   state_e                                state_q, state_d;
   logic                                  ready_q, ready_d;
   logic                                  on_q, on_d;
   logic [NOTE_W-1:0]                     note_q, note_d;
   logic [INC_W-1:0]                      inc_q, inc_d;
   logic [IDX_W-1:0]                      idx_q, idx_d;
   logic                                  match_vld_q, match_vld_d;
   logic [IDX_W-1:0]                      match_q, match_d;
   logic                                  free_vld_q, free_vld_d;
   logic [IDX_W-1:0]                      free_q, free_d;
   logic [IDX_W-1:0]                      oldest_q, oldest_d;
   logic [IDX_W-1:0]                      target_q, target_d;
   logic                                  drop_q, drop_d;
   logic [CNT_W-1:0]                      gap_cnt_q, gap_cnt_d;
   logic [NUM_VOICES-1:0]                 gate_q, gate_d;
   logic [NUM_VOICES-1:0][INC_W-1:0]      vinc_q, vinc_d;
   logic [NUM_VOICES-1:0][NOTE_W-1:0]     vnote_q, vnote_d;
   logic [NUM_VOICES-1:0][IDX_W-1:0]      age_q, age_d;
   logic                                  stolen_q, stolen_d;

   // Scan results including the voice examined this cycle
   logic                                  m_vld, f_vld;
   logic [IDX_W-1:0]                      m_idx, f_idx, o_idx;

   // Next-state and output logic
   always_comb begin
      state_d     = state_q;
      on_d        = on_q;
      note_d      = note_q;
      inc_d       = inc_q;
      idx_d       = idx_q;
      match_vld_d = match_vld_q;
      match_d     = match_q;
      free_vld_d  = free_vld_q;
      free_d      = free_q;
      oldest_d    = oldest_q;
      target_d    = target_q;
      drop_d      = drop_q;
      gap_cnt_d   = gap_cnt_q;
      gate_d      = gate_q;
      vinc_d      = vinc_q;
      vnote_d     = vnote_q;
      age_d       = age_q;
      stolen_d    = 1'b0;

      // Lowest index wins for match/free, so only the first hit is recorded
      m_vld = match_vld_q;
      m_idx = match_q;
      f_vld = free_vld_q;
      f_idx = free_q;
      o_idx = oldest_q;
      if (!match_vld_q && gate_q[idx_q] && (vnote_q[idx_q] == note_q)) begin
         m_vld = 1'b1;
         m_idx = idx_q;
      end
      if (!free_vld_q && !gate_q[idx_q]) begin
         f_vld = 1'b1;
         f_idx = idx_q;
      end
      if (age_q[idx_q] == IDX_W'(NUM_VOICES - 1)) begin
         o_idx = idx_q;
      end

      case (state_q)
         S_IDLE: begin
            if (ev_valid_i) begin
               on_d        = ev_on_i;
               note_d      = ev_note_i;
               inc_d       = ev_increment_i;
               idx_d       = '0;
               match_vld_d = 1'b0;
               free_vld_d  = 1'b0;
               state_d     = S_SCAN;
            end
         end
         S_SCAN: begin
            match_vld_d = m_vld;
            match_d     = m_idx;
            free_vld_d  = f_vld;
            free_d      = f_idx;
            oldest_d    = o_idx;
            if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
               state_d = S_COMMIT;
               drop_d  = 1'b0;
               if (on_q) begin
                  if (m_vld) begin
                     target_d = m_idx;
                  end else if (f_vld) begin
                     target_d = f_idx;
                  end else begin
                     // Steal: silence the oldest voice for the gap first
                     target_d        = o_idx;
                     gate_d[o_idx]   = 1'b0;
                     stolen_d        = 1'b1;
                     gap_cnt_d       = '0;
                     state_d         = S_GAP;
                  end
               end else begin
                  target_d = m_idx;
                  drop_d   = !m_vld;
               end
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         S_GAP: begin
            if (gap_cnt_q == CNT_W'(GATE_GAP - 1)) begin
               state_d = S_COMMIT;
            end else begin
               gap_cnt_d = gap_cnt_q + CNT_W'(1);
            end
         end
         S_COMMIT: begin
            if (on_q) begin
               vinc_d[target_q]  = inc_q;
               vnote_d[target_q] = note_q;
               gate_d[target_q]  = 1'b1;
               // Move target to youngest; voices younger than it age by one
               for (int j = 0; j < int'(NUM_VOICES); j++) begin
                  if (age_q[j] < age_q[target_q]) begin
                     age_d[j] = age_q[j] + IDX_W'(1);
                  end
               end
               age_d[target_q] = '0;
            end else if (!drop_q) begin
               gate_d[target_q] = 1'b0;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Panic overrides everything, including a same-cycle handshake
      if (all_off_i) begin
         gate_d   = '0;
         stolen_d = 1'b0;
         state_d  = S_IDLE;
      end

      ready_d = (state_d == S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         ready_q     <= 1'b1;
         on_q        <= 1'b0;
         note_q      <= '0;
         inc_q       <= '0;
         idx_q       <= '0;
         match_vld_q <= 1'b0;
         match_q     <= '0;
         free_vld_q  <= 1'b0;
         free_q      <= '0;
         oldest_q    <= '0;
         target_q    <= '0;
         drop_q      <= 1'b0;
         gap_cnt_q   <= '0;
         gate_q      <= '0;
         vinc_q      <= '0;
         vnote_q     <= '0;
         for (int i = 0; i < int'(NUM_VOICES); i++) begin
            age_q[i] <= IDX_W'(i);
         end
         stolen_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         on_q        <= on_d;
         note_q      <= note_d;
         inc_q       <= inc_d;
         idx_q       <= idx_d;
         match_vld_q <= match_vld_d;
         match_q     <= match_d;
         free_vld_q  <= free_vld_d;
         free_q      <= free_d;
         oldest_q    <= oldest_d;
         target_q    <= target_d;
         drop_q      <= drop_d;
         gap_cnt_q   <= gap_cnt_d;
         gate_q      <= gate_d;
         vinc_q      <= vinc_d;
         vnote_q     <= vnote_d;
         age_q       <= age_d;
         stolen_q    <= stolen_d;
      end
   end

   assign ev_ready_o   = ready_q;
   assign voice_inc_o  = vinc_q;
   assign voice_gate_o = gate_q;
   assign stolen_o     = stolen_q;

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed bench for voice_allocator (4 voices, 512-cycle gap).
module tb_voice_allocator;

   localparam int NV   = 4;
   localparam int GAP  = 512;
   localparam int LAT  = NV + 2;
   localparam int LATS = NV + 2 + GAP;

   logic        clk, rst_n;
   logic        ev_valid, ev_ready, ev_on, all_off, stolen;
   logic [6:0]  ev_note;
   logic [15:0] ev_inc;
   logic [63:0] voice_inc;
   logic [3:0]  voice_gate;

   int n_checks = 0;
   int n_fail   = 0;

   voice_allocator #(.NUM_VOICES(NV), .NOTE_W(7), .INC_W(16), .GATE_GAP(GAP)) dut (
      .clk_i(clk), .rst_ni(rst_n), .ev_valid_i(ev_valid), .ev_ready_o(ev_ready),
      .ev_on_i(ev_on), .ev_note_i(ev_note), .ev_increment_i(ev_inc),
      .all_off_i(all_off), .voice_inc_o(voice_inc), .voice_gate_o(voice_gate),
      .stolen_o(stolen));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        on;
      logic [6:0]  note;
      logic [15:0] inc;
      logic [3:0]  gate;
      logic [63:0] incs;
      logic        st;
      int          lat;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Issue one event at a negedge; returns whether stolen pulsed and the cycle ready returned
   task automatic send(input logic on, input logic [6:0] note, input logic [15:0] inc,
                       output logic st, output int lat);
      int w;
      w = 0;
      while (!ev_ready && w < 2000) begin
         @(negedge clk);
         w++;
      end
      ev_valid = 1'b1;
      ev_on    = on;
      ev_note  = note;
      ev_inc   = inc;
      @(negedge clk);
      ev_valid = 1'b0;
      st  = 1'b0;
      lat = 0;
      for (int k = 1; k <= 2000; k++) begin
         if (stolen) st = 1'b1;
         if (ev_ready) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      logic st;
      int   lat;
      logic dropped;

      vecs[0]  = '{1'b1, 7'd60, 16'h0112, 4'b0001, 64'h0000_0000_0000_0112, 1'b0, LAT};
      vecs[1]  = '{1'b1, 7'd62, 16'h0126, 4'b0011, 64'h0000_0000_0126_0112, 1'b0, LAT};
      vecs[2]  = '{1'b1, 7'd64, 16'h014A, 4'b0111, 64'h0000_014A_0126_0112, 1'b0, LAT};
      vecs[3]  = '{1'b1, 7'd65, 16'h015D, 4'b1111, 64'h015D_014A_0126_0112, 1'b0, LAT};
      vecs[4]  = '{1'b1, 7'd67, 16'h0187, 4'b1111, 64'h015D_014A_0126_0187, 1'b1, LATS};
      vecs[5]  = '{1'b1, 7'd72, 16'h01EE, 4'b1111, 64'h015D_014A_01EE_0187, 1'b1, LATS};
      vecs[6]  = '{1'b0, 7'd64, 16'hFFFF, 4'b1011, 64'h015D_014A_01EE_0187, 1'b0, LAT};
      vecs[7]  = '{1'b0, 7'd70, 16'hFFFF, 4'b1011, 64'h015D_014A_01EE_0187, 1'b0, LAT};
      vecs[8]  = '{1'b1, 7'd67, 16'h0999, 4'b1011, 64'h015D_014A_01EE_0999, 1'b0, LAT};
      vecs[9]  = '{1'b1, 7'd64, 16'h0150, 4'b1111, 64'h015D_0150_01EE_0999, 1'b0, LAT};
      vecs[10] = '{1'b1, 7'd80, 16'h0280, 4'b1111, 64'h0280_0150_01EE_0999, 1'b1, LATS};
      vecs[11] = '{1'b1, 7'd81, 16'h0281, 4'b1111, 64'h0280_0150_0281_0999, 1'b1, LATS};
      vecs[12] = '{1'b0, 7'd65, 16'hFFFF, 4'b1111, 64'h0280_0150_0281_0999, 1'b0, LAT};
      vecs[13] = '{1'b0, 7'd81, 16'hFFFF, 4'b1101, 64'h0280_0150_0281_0999, 1'b0, LAT};

      ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0; ev_inc = '0; all_off = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset gate", 64'(voice_gate), 64'h0);
      check("reset inc", voice_inc, 64'h0);
      check("reset stolen", 64'(stolen), 64'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset ready", 64'(ev_ready), 64'h1);

      // Table: allocation, steals, note-off, retrigger, dropped off
      for (int i = 0; i < 14; i++) begin
         send(vecs[i].on, vecs[i].note, vecs[i].inc, st, lat);
         check($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
         check($sformatf("v%0d gate", i), 64'(voice_gate), 64'(vecs[i].gate));
         check($sformatf("v%0d incs", i), voice_inc, vecs[i].incs);
         check($sformatf("v%0d stolen", i), 64'(st), 64'(vecs[i].st));
      end

      // Steal gap: oldest gate held low for the whole gap, then re-gated
      do_reset();
      send(1'b1, 7'd10, 16'h0010, st, lat);
      send(1'b1, 7'd11, 16'h0011, st, lat);
      send(1'b1, 7'd12, 16'h0012, st, lat);
      send(1'b1, 7'd13, 16'h0013, st, lat);
      ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd14; ev_inc = 16'h0014;
      @(negedge clk);
      ev_valid = 1'b0;
      begin
         int low_cnt;
         low_cnt = 0;
         for (int k = 1; k <= LATS + 2; k++) begin
            if (!voice_gate[0]) low_cnt++;
            @(negedge clk);
         end
         check("gap low cycles", 64'(low_cnt), 64'(GAP + 1));
      end
      check("gap final gate", 64'(voice_gate), 64'hF);
      check("gap final incs", voice_inc, 64'h0013_0012_0011_0014);

      // Retrigger: same note twice keeps gate high, only one voice gated
      do_reset();
      send(1'b1, 7'd60, 16'h0112, st, lat);
      ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd60; ev_inc = 16'h0333;
      @(negedge clk);
      ev_valid = 1'b0;
      dropped = 1'b0;
      for (int k = 1; k <= LAT + 2; k++) begin
         if (voice_gate !== 4'b0001) dropped = 1'b1;
         @(negedge clk);
      end
      check("retrig gate stable", 64'(dropped), 64'h0);
      check("retrig inc", voice_inc, 64'h0000_0000_0000_0333);

      // all_off during GAP: gates drop next cycle, event abandoned
      send(1'b1, 7'd61, 16'h0161, st, lat);
      send(1'b1, 7'd62, 16'h0162, st, lat);
      send(1'b1, 7'd63, 16'h0163, st, lat);
      check("pre-panic gate", 64'(voice_gate), 64'hF);
      ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd90; ev_inc = 16'h0900;
      @(negedge clk);
      ev_valid = 1'b0;
      repeat (19) @(negedge clk);
      check("in-gap gate", 64'(voice_gate), 64'hE);
      all_off = 1'b1;
      @(negedge clk);
      all_off = 1'b0;
      check("panic gate", 64'(voice_gate), 64'h0);
      check("panic ready", 64'(ev_ready), 64'h1);
      st = 1'b0;
      dropped = 1'b0;
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         if (stolen) st = 1'b1;
         if (voice_gate !== 4'b0000) dropped = 1'b1;
      end
      check("panic no stolen", 64'(st), 64'h0);
      check("panic no commit gate", 64'(dropped), 64'h0);
      check("panic incs kept", voice_inc, 64'h0163_0162_0161_0333);

      // all_off beats a same-cycle ev_valid
      ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd99; ev_inc = 16'h0999;
      all_off = 1'b1;
      @(negedge clk);
      ev_valid = 1'b0; all_off = 1'b0;
      check("panic+valid ready", 64'(ev_ready), 64'h1);
      repeat (LAT + 2) @(negedge clk);
      check("panic+valid gate", 64'(voice_gate), 64'h0);
      check("panic+valid incs", voice_inc, 64'h0163_0162_0161_0333);

      // Async reset mid-SCAN
      ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd50; ev_inc = 16'h0AAA;
      @(negedge clk);
      ev_valid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async rst gate", 64'(voice_gate), 64'h0);
      check("async rst incs", voice_inc, 64'h0);
      check("async rst stolen", 64'(stolen), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post rst ready", 64'(ev_ready), 64'h1);
      send(1'b1, 7'd20, 16'h0020, st, lat);
      check("post rst first lat", 64'(lat), 64'(LAT));
      check("post rst first", voice_inc, 64'h0000_0000_0000_0020);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time bound
   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
